// File: rtl/spram_arb_pkg.sv
// Shared definitions for the sport_ram arbiter slice.
//   - state_t     : sequencer states (IDLE -> ACCESS -> RESP -> IDLE)
//   - DATA_W_DEF  : default RAM word width
//   - ADDR_W_DEF  : default RAM address width (depth = 2**ADDR_W)
package spram_arb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/sport_ram_arbiter_if.sv
// Client-side bundle of the sport_ram arbiter.
//   req[1:0]      client i requests an access (held until gnt[i])
//   req_we[1:0]   client i: 1 = write, 0 = read
//   req_addr0/1   client 0/1 address
//   req_wdata0/1  client 0/1 write data
//   gnt[1:0]      one-hot accept strobe (combinational)
//   done[1:0]     one-hot completion pulse (registered)
//   rdata         read data, valid while done[i]=1 for a read
//   busy          arbiter is not idle
// Modports: master = client logic, slave = arbiter.
interface sport_ram_arbiter_if
  import spram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [1:0]        req;
  logic [1:0]        req_we;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  gnt, done, rdata, busy
  );

  modport slave (
    input  req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output gnt, done, rdata, busy
  );

endinterface

// File: rtl/spram_rr_pick.sv
// Two-way round-robin picker (purely combinational).
//   req[1:0]  pending requests
//   pri       index of the favoured client when both request
//   win[1:0]  one-hot winner, 2'b00 when nothing requests
module spram_rr_pick (
  input  logic [1:0] req,
  input  logic       pri,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    // A lone requester always wins; only a tie consults the priority bit.
    if (req == 2'b11) begin
      win = pri ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/sport_ram_arbiter.sv
// Two-requester round-robin arbiter / sequencer for the 8x16 single-port RAM.
// Each accepted request takes exactly three cycles: IDLE (gnt) -> ACCESS
// (registered ram_* pins drive the RAM) -> RESP (done pulse) -> IDLE.
// RAM pin convention: write = ram_we & !ram_en, read = ram_en & !ram_we.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cif (slave)           client request / grant / completion bundle
//   ram_we, ram_en        registered RAM write strobe / read enable
//   ram_addr, ram_wdata   registered RAM address / write data
//   ram_rdata             RAM read data, sampled at the end of ACCESS
//   cnt0, cnt1            completed-access counters (SPRAM_ARB_STATS_EN only)
// Build option: define SPRAM_ARB_STATS_EN to add the per-client counters.
module sport_ram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
`ifdef SPRAM_ARB_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  sport_ram_arbiter_if.slave cif,
  output logic              ram_we,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef SPRAM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
`endif
);

  state_t            state_q, state_d;
  logic              pri_q;        // favoured client index for the next tie
  logic [1:0]        win_q;        // one-hot owner of the access in flight
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        pick_win;
  logic              pick_sel;     // index of the picked client
  logic [1:0]        gnt_d;
  logic              ram_we_d, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_d;

  spram_rr_pick u_pick (
    .req (cif.req),
    .pri (pri_q),
    .win (pick_win)
  );

  assign pick_sel = pick_win[1];

  // Next-state and next-pin logic. The ram_* pins are registered, so their
  // ACCESS values are computed while still in IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    gnt_d       = 2'b00;
    done_d      = 2'b00;
    ram_we_d    = 1'b0;
    ram_en_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (|cif.req) begin
          gnt_d      = pick_win;
          state_d    = ST_ACCESS;
          ram_we_d   = cif.req_we[pick_sel];
          ram_en_d   = !cif.req_we[pick_sel];
          ram_addr_d = pick_sel ? cif.req_addr1 : cif.req_addr0;
          if (cif.req_we[pick_sel]) begin
            ram_wdata_d = pick_sel ? cif.req_wdata1 : cif.req_wdata0;
          end
        end
      end
      ST_ACCESS: begin
        done_d  = win_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pri_q     <= 1'b0;
      win_q     <= 2'b00;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      ram_we    <= 1'b0;
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this clock edge.
      state_q   <= state_d;
      done_q    <= done_d;
      ram_we    <= ram_we_d;
      ram_en    <= ram_en_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;

      if (state_q == ST_IDLE && |cif.req) begin
        win_q <= pick_win;
      end
      // The registered read enable marks a read in flight; writes keep rdata.
      if (state_q == ST_ACCESS && ram_en) begin
        rdata_q <= ram_rdata;
      end
      // Favour the other client once this access completes.
      if (state_q == ST_RESP) begin
        pri_q <= !win_q[1];
      end
    end
  end

`ifdef SPRAM_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Counters advance in the RESP cycle, i.e. together with each done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (state_q == ST_RESP) begin
      if (win_q[1]) begin
        cnt1 <= cnt1 + CNT_ONE;
      end else begin
        cnt0 <= cnt0 + CNT_ONE;
      end
    end
  end
`endif

  // Grant is suppressed while reset is held so nothing looks accepted.
  assign cif.gnt   = rst_n ? gnt_d : 2'b00;
  assign cif.done  = done_q;
  assign cif.rdata = rdata_q;
  assign cif.busy  = (state_q != ST_IDLE);

endmodule
